deser_fifo_p: RTL

- Parametrised serial-to-parallel queue: collects DATA_WIDTH bits from a strobed 1-bit serial input, assembles words, and stores them in a DEPTH-entry circular FIFO.
- Words are popped on request onto a parallel output, with a valid pulse, an occupancy count and overflow/underflow flags.
- Successor to the fixed 8-bit deserializer/queue pair behind the top level, generalised in word width, depth and bit order, and adding partial-word flush and error flags.

---
 rtl/deser_fifo_p.sv | 120 ++++++++++++
 1 files changed

// File: rtl/deser_fifo_p.sv
// deser_fifo_p: serial-to-parallel word assembler feeding a DEPTH-entry
// circular FIFO. Bits arrive on a strobed 1-bit input, complete words (or a
// flushed partial word) are pushed, and words are popped onto a registered
// parallel output with a one-cycle valid pulse.
//
// Optional build macro: DESER_FIFO_ALMOST_FULL_EN adds a registered
// almost_full_out flag, high when the stored word count is >= AF_LEVEL.
module deser_fifo_p #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int AF_LEVEL   = DEPTH - 1
) (
  input  logic                         clock_1MHz,
  input  logic                         rst,
  input  logic                         data_in,
  input  logic                         write_in,
  input  logic                         enqueue_in,
  input  logic                         dequeue_in,
  output logic                         status_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic                         overflow_out,
`ifdef DESER_FIFO_ALMOST_FULL_EN
  output logic                         almost_full_out,
`endif
  output logic                         underflow_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] sreg, sreg_nxt, flush_word, push_word;
  logic [BW-1:0]         bit_cnt, bits_nxt, pad;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  full, accept, drop, word_done, flush_req, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state decode: bit acceptance, word completion, flush and pop.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    sreg_nxt = sreg;
    full     = (count == CW'(DEPTH));
    accept   = write_in && !full;
    drop     = write_in && full;
    if (accept) begin
      if (MSB_FIRST != 0) sreg_nxt = {sreg[DATA_WIDTH-2:0], data_in};
      else                sreg_nxt = {data_in, sreg[DATA_WIDTH-1:1]};
    end
    bits_nxt  = accept ? bit_cnt + 1'b1 : bit_cnt;
    word_done = accept && (bit_cnt == BW'(DATA_WIDTH - 1));
    flush_req = enqueue_in && (bits_nxt != '0) && !word_done;
    // Received bits sit at the shift-in end; shifting by the unreceived
    // count aligns them and zero-fills the rest, discarding stale bits.
    pad = BW'(DATA_WIDTH) - bits_nxt;
    if (MSB_FIRST != 0) flush_word = sreg_nxt << pad;
    else                flush_word = sreg_nxt >> pad;
    push_word = word_done ? sreg_nxt : flush_word;
    push      = word_done || (flush_req && !full);
    pop       = dequeue_in && (count != '0);
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  assign status_out = !full;
  assign count_out  = count;

  // Control state: shift register, bit counter, pointers, count, output and flags.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      sreg          <= '0;
      bit_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
`ifdef DESER_FIFO_ALMOST_FULL_EN
      almost_full_out <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      sreg    <= sreg_nxt;
      bit_cnt <= (word_done || flush_req) ? '0 : bits_nxt;
      count   <= count_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        data_out <= mem[rd_ptr];
      end
      valid_out <= pop;
      if (drop || (flush_req && full)) overflow_out  <= 1'b1;
      if (dequeue_in && (count == '0)) underflow_out <= 1'b1;
`ifdef DESER_FIFO_ALMOST_FULL_EN
      almost_full_out <= (int'(count_nxt) >= AF_LEVEL);
`endif
    end
  end

  // Storage array write port.
  // NOTE: the array is deliberately not reset; the pointers and count define
  // which entries are valid, and leaving it unreset keeps it mappable to RAM.
  always_ff @(posedge clock_1MHz) begin
    if (push) mem[wr_ptr] <= push_word;
  end

endmodule
